// File: rtl/alu_ctrl_pkg.sv
// Shared codes, funct values and FSM states for the ALU control unit.
// Optional shift decode is enabled by ALU_CTRL_SHIFT_EN (see alu_ctrl_decode).
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_ILL  = 4'b1111;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_RSV   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MDU  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {alu_op, funct} decode to ALU code, illegal and MDU flags.
// ALU_CTRL_SHIFT_EN adds sll/srl/sra; otherwise those functs are illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       illegal,
  output logic       is_mdu,
  output logic       mdu_op
);

  always_comb begin
    code    = ALU_ILL;
    illegal = 1'b1;
    is_mdu  = 1'b0;
    mdu_op  = 1'b0;
    unique case (1'b1)
      alu_op == ALU_OP_ADD: begin
        code    = ALU_ADD;
        illegal = 1'b0;
      end
      alu_op == ALU_OP_SUB: begin
        code    = ALU_SUB;
        illegal = 1'b0;
      end
      alu_op == ALU_OP_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNCT_ADD: code = ALU_ADD;
          FUNCT_SUB: code = ALU_SUB;
          FUNCT_AND: code = ALU_AND;
          FUNCT_OR:  code = ALU_OR;
          FUNCT_NOR: code = ALU_NOR;
          FUNCT_SLT: code = ALU_SLT;
          FUNCT_MULT: begin
            code   = ALU_MULT;
            is_mdu = 1'b1;
          end
          FUNCT_DIV: begin
            code   = ALU_DIV;
            is_mdu = 1'b1;
            mdu_op = 1'b1;
          end
`ifdef ALU_CTRL_SHIFT_EN
          FUNCT_SLL: code = ALU_SLL;
          FUNCT_SRL: code = ALU_SRL;
          FUNCT_SRA: code = ALU_SRA;
`endif
          default: illegal = 1'b1;
        endcase
      end
      alu_op == ALU_OP_RSV: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with valid/ready handshake and MULT/DIV sequencing.
// Shift decode is optional via ALU_CTRL_SHIFT_EN (handled in alu_ctrl_decode).
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTL_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTL_W-1:0] alu_ctl,
  output logic             illegal,
  output logic             mdu_start,
  output logic             mdu_op,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [3:0] dec_code;
  logic       dec_ill;
  logic       dec_mdu;
  logic       dec_op;

  alu_ctrl_decode u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .code    (dec_code),
    .illegal (dec_ill),
    .is_mdu  (dec_mdu),
    .mdu_op  (dec_op)
  );

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ov_nx, ill_nx, start_nx, op_nx;
  logic [CTL_W-1:0] ctl_nx;
  logic             accept;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_MDU);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ov_nx    = out_valid;
    ctl_nx   = alu_ctl;
    ill_nx   = illegal;
    start_nx = 1'b0;
    op_nx    = mdu_op;
    unique case (state)
      ST_IDLE: begin
        if (accept && dec_mdu) begin
          state_nx = ST_MDU;
          cnt_nx   = dec_op ? DIV_CNT : MUL_CNT;
          op_nx    = dec_op;
          start_nx = 1'b1;
          ov_nx    = 1'b0;
        end else if (accept) begin
          ov_nx  = 1'b1;
          ctl_nx = CTL_W'(dec_code);
          ill_nx = dec_ill;
        end else if (out_ready) begin
          ov_nx = 1'b0;
        end
      end
      ST_MDU: begin
        // Result appears on the edge the counter is seen at zero
        if (cnt == '0) begin
          state_nx = ST_IDLE;
          ov_nx    = 1'b1;
          ctl_nx   = CTL_W'(mdu_op ? ALU_DIV : ALU_MULT);
          ill_nx   = 1'b0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_ctl   <= '0;
      illegal   <= 1'b0;
      mdu_start <= 1'b0;
      mdu_op    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      out_valid <= ov_nx;
      alu_ctl   <= ctl_nx;
      illegal   <= ill_nx;
      mdu_start <= start_nx;
      mdu_op    <= op_nx;
    end
  end

endmodule
